imm_encoder: RTL
================

Name: imm_encoder

Overview:
- Inverse of the immediate generator: assembles a 32-bit RV32I instruction word from a format code, register fields and a 32-bit immediate value.
- Sits between the debug/boot-loader command path and the instruction-injection port. It lets firmware-less tooling synthesize instructions at run time.
- Also expands the "li rd, imm32" pseudo-instruction into ADDI, LUI, or LUI+ADDI. This uses a small state machine with valid/ready handshakes on both sides.

Parameters:
- none. Opcode constants come from Parametros.v: OPC_LUI, OPC_OPIMM.

Ports:
- iCLK       input   1   system clock, all state on rising edge
- iRST       input   1   synchronous, active-high reset
- iCmdValid  input   1   command present
- oCmdReady  output  1   command accepted when iCmdValid&&oCmdReady
- iFmt       input   3   0=R 1=I 2=S 3=B 4=U 5=J 6=LI 7=reserved
- iOpcode    input   7   opcode field, ignored for LI
- iRd        input   5   destination register
- iRs1       input   5   source 1
- iRs2       input   5   source 2
- iFunct3    input   3   funct3, ignored for U/J/LI
- iFunct7    input   7   funct7, R only
- iImm       input   32  immediate value, full byte offset/value (not pre-shifted)
- oInstrValid  output  1   oInstr valid
- iInstrReady  input   1   consumer accepts when oInstrValid&&iInstrReady
- oInstr     output  32  encoded instruction
- oRangeErr  output  1   immediate not representable in format, qualified by oInstrValid
- oLast      output  1   final word of the current command, qualified by oInstrValid

Behaviour:
- Reset: oInstrValid=0, oInstr=0, oRangeErr=0, oLast=0, state=IDLE. oCmdReady=1 after reset.
- Output register: a single-entry buffer. The buffer is free when !oInstrValid || iInstrReady.
- While oInstrValid=1 and iInstrReady=0, oInstr, oRangeErr and oLast are held stable.
- States:
  - IDLE: oCmdReady = buffer free.
  - LI2: oCmdReady=0.
- Latency: on an accepted command, the first word appears registered on the next cycle.
- Field packing per format, for opcode op, rd, rs1, rs2, f3, f7:
  - R: {f7, rs2, rs1, f3, rd, op}.
  - I: {imm[11:0], rs1, f3, rd, op}; legal range -2048..2047.
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}; legal range -2048..2047.
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}; legal range -4096..4094 and imm[0]=0.
  - U: {imm[31:12], rd, op}; legal only if imm[11:0]=0.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}; legal range -2^20..2^20-2 and imm[0]=0.
  - R is never a range error.
- Range error: an illegal immediate is still encoded by bit truncation, and oRangeErr=1 on that word.
- Reserved fmt 7: emits oInstr=0, oRangeErr=1, oLast=1.
- LI expansion (rd=iRd; immediate captured in an internal register at accept):
  - If imm is in -2048..2047: one word, ADDI rd,x0,imm[11:0]; oLast=1.
  - Else if imm[11:0]=0: one word, LUI rd,imm[31:12]; oLast=1.
  - Else: first word LUI rd,hi, where hi=(imm+32'h800)[31:12], 32-bit wrap allowed; oLast=0. Go to LI2.
  - In LI2, when the buffer is free, load ADDI rd,rd,imm[11:0] with oLast=1, then return to IDLE.
  - LI never sets oRangeErr.
- Non-LI commands always produce one word with oLast=1.
- Back-to-back operation: accepting a command in the same cycle the consumer takes the current word gives one word per cycle, with no bubble.
- Reset mid-operation (including in LI2 or with a word pending): pending output is dropped and the state returns to IDLE. No partial word is emitted after reset.
- rd=x0 is encoded as given, with no special case.

Test Plan:
- I, op=0010011, rd=5, rs1=0, f3=0, imm=32'hFFFFFFFF -> oInstr=32'hFFF00293, oRangeErr=0, oLast=1, one cycle after accept.
- B, op=1100011, rs1=1, rs2=2, f3=0, imm=8 -> 32'h00208463. Repeat with imm=3 -> oRangeErr=1. Repeat with imm=4096 -> oRangeErr=1.
- J, op=1101111, rd=1, imm=2048 -> 32'h001000EF, oRangeErr=0.
- LI rd=10, imm=32'h12345FFF -> first word 32'h12346537 (oLast=0), then 32'hFFF50513 (oLast=1). oCmdReady must stay 0 between the two words.
- LI rd=1, imm=32'h00001000 -> single word 32'h000010B7, oLast=1. LI rd=1, imm=-5 -> single word 32'hFFB00093.
- Backpressure and reset:
  - Hold iInstrReady=0 for 3 cycles during the LI first word -> oInstr stable, oCmdReady=0.
  - Assert iRST in LI2 -> the next cycle shows oInstrValid=0 and oCmdReady=1, and the ADDI word is never emitted.

Source files
------------

// File: rtl/imm_encoder_if.sv
// Command and instruction-stream bundle for imm_encoder.
// slave is the encoder's view and master is the command source / consumer view.
interface imm_encoder_if;
    logic        iCmdValid;
    logic        oCmdReady;
    logic [2:0]  iFmt;
    logic [6:0]  iOpcode;
    logic [4:0]  iRd;
    logic [4:0]  iRs1;
    logic [4:0]  iRs2;
    logic [2:0]  iFunct3;
    logic [6:0]  iFunct7;
    logic [31:0] iImm;
    logic        oInstrValid;
    logic        iInstrReady;
    logic [31:0] oInstr;
    logic        oRangeErr;
    logic        oLast;

    modport slave (
        input  iCmdValid, iFmt, iOpcode, iRd, iRs1, iRs2, iFunct3, iFunct7, iImm,
        input  iInstrReady,
        output oCmdReady, oInstrValid, oInstr, oRangeErr, oLast
    );

    modport master (
        output iCmdValid, iFmt, iOpcode, iRd, iRs1, iRs2, iFunct3, iFunct7, iImm,
        output iInstrReady,
        input  oCmdReady, oInstrValid, oInstr, oRangeErr, oLast
    );
endinterface

// File: rtl/imm_encoder.sv
// Assembles RV32I instruction words from format, register fields and an immediate.
// Also expands "li rd, imm32" into ADDI, LUI or LUI+ADDI through a one-entry output buffer.
module imm_encoder (
    input logic iCLK,
    input logic iRST,
    imm_encoder_if.slave bus
);
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [2:0] FMT_R  = 3'd0;
    localparam logic [2:0] FMT_I  = 3'd1;
    localparam logic [2:0] FMT_S  = 3'd2;
    localparam logic [2:0] FMT_B  = 3'd3;
    localparam logic [2:0] FMT_U  = 3'd4;
    localparam logic [2:0] FMT_J  = 3'd5;
    localparam logic [2:0] FMT_LI = 3'd6;

    typedef enum logic {IDLE, LI2} state_t;

    state_t      state, next_state;
    logic        vld_p0;
    logic [31:0] instr_p0;
    logic        err_p0;
    logic        last_p0;
    logic [4:0]  li_rd;
    logic [11:0] li_lo;

    logic        buf_free;
    logic        load;
    logic        capture_li;
    logic [31:0] nxt_instr;
    logic        nxt_err;
    logic        nxt_last;
    logic signed [31:0] imm_s;
    logic [31:0] li_hi;

    function automatic logic [31:0] pack(
        input logic [2:0]  fmt,
        input logic [6:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        case (fmt)
            FMT_R:   pack = {f7, rs2, rs1, f3, rd, op};
            FMT_I:   pack = {imm[11:0], rs1, f3, rd, op};
            FMT_S:   pack = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FMT_B:   pack = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            FMT_U:   pack = {imm[31:12], rd, op};
            FMT_J:   pack = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: pack = 32'd0;
        endcase
    endfunction

    // Out-of-range immediates are still encoded by truncation; this only flags them.
    function automatic logic range_err(input logic [2:0] fmt, input logic signed [31:0] imm);
        case (fmt)
            FMT_I, FMT_S: range_err = (imm < -32'sd2048) || (imm > 32'sd2047);
            FMT_B:        range_err = (imm < -32'sd4096) || (imm > 32'sd4094) || imm[0];
            FMT_U:        range_err = (imm[11:0] != 12'd0);
            FMT_J:        range_err = (imm < -32'sd1048576) || (imm > 32'sd1048574) || imm[0];
            default:      range_err = 1'b0;
        endcase
    endfunction

    assign buf_free = !vld_p0 || bus.iInstrReady;
    assign imm_s    = bus.iImm;
    // Rounding the upper part lets the sign-extended ADDI low half land exactly on imm.
    assign li_hi    = bus.iImm + 32'h0000_0800;

    always_comb begin
        next_state    = state;
        load          = 1'b0;
        capture_li    = 1'b0;
        nxt_instr     = 32'd0;
        nxt_err       = 1'b0;
        nxt_last      = 1'b1;
        bus.oCmdReady = 1'b0;
        case (state)
            IDLE: begin
                bus.oCmdReady = buf_free;
                if (bus.iCmdValid && buf_free) begin
                    load = 1'b1;
                    if (bus.iFmt == FMT_LI) begin
                        if ((imm_s >= -32'sd2048) && (imm_s <= 32'sd2047)) begin
                            nxt_instr = {bus.iImm[11:0], 5'd0, 3'b000, bus.iRd, OPC_OPIMM};
                        end else if (bus.iImm[11:0] == 12'd0) begin
                            nxt_instr = {bus.iImm[31:12], bus.iRd, OPC_LUI};
                        end else begin
                            nxt_instr  = {li_hi[31:12], bus.iRd, OPC_LUI};
                            nxt_last   = 1'b0;
                            capture_li = 1'b1;
                            next_state = LI2;
                        end
                    end else if (bus.iFmt == 3'd7) begin
                        nxt_err = 1'b1;
                    end else begin
                        nxt_instr = pack(bus.iFmt, bus.iOpcode, bus.iRd, bus.iRs1, bus.iRs2,
                                         bus.iFunct3, bus.iFunct7, bus.iImm);
                        nxt_err   = range_err(bus.iFmt, imm_s);
                    end
                end
            end
            LI2: begin
                if (buf_free) begin
                    load       = 1'b1;
                    nxt_instr  = {li_lo, li_rd, 3'b000, li_rd, OPC_OPIMM};
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output buffer stage
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state    <= IDLE;
            vld_p0   <= 1'b0;
            instr_p0 <= 32'd0;
            err_p0   <= 1'b0;
            last_p0  <= 1'b0;
        end else begin
            state <= next_state;
            if (load) begin
                vld_p0   <= 1'b1;
                instr_p0 <= nxt_instr;
                err_p0   <= nxt_err;
                last_p0  <= nxt_last;
            end else if (bus.iInstrReady) begin
                vld_p0 <= 1'b0;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (capture_li) begin
            li_rd <= bus.iRd;
            li_lo <= bus.iImm[11:0];
        end
    end

    assign bus.oInstrValid = vld_p0;
    assign bus.oInstr      = instr_p0;
    assign bus.oRangeErr   = err_p0;
    assign bus.oLast       = last_p0;
endmodule
